// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage 16-bit pipeline.
// Tracks an EX shadow, multiply occupancy and the HALT drain sequence.
module hazard_ctrl #(
   parameter int unsigned MUL_LATENCY  = 3,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [3:0]  id_rs1,
   input  logic [3:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [3:0]  id_rd,
   input  logic        id_writes_rd,
   input  logic        id_is_load,
   input  logic        id_is_mul,
   input  logic        id_is_halt,
   input  logic        ex_branch_taken,
   output logic        stall_pc,
   output logic        ifid_hold,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        halted,
   output logic [15:0] stall_count
);

   localparam int unsigned DW =
      (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
   localparam logic [3:0]    MUL_INIT   = 4'(MUL_LATENCY - 1);

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_DRAIN  = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          ex_valid_q, ex_valid_d;
   logic [3:0]    ex_rd_q, ex_rd_d;
   logic          ex_writes_q, ex_writes_d;
   logic          ex_is_load_q, ex_is_load_d;
   logic [3:0]    mul_cnt_q, mul_cnt_d;
   logic [DW-1:0] drain_cnt_q, drain_cnt_d;
   logic [15:0]   stall_cnt_q, stall_cnt_d;

   logic run, in_drain, in_halted;
   logic mul_busy, rs1_hit, rs2_hit, load_use;
   logic m_flush, m_mul, m_lu, issue;
   logic stall_r, hold_r, flush_r, bubble_r;

   always_comb begin
      run       = (state_q == S_RUN);
      in_drain  = (state_q == S_DRAIN);
      in_halted = (state_q == S_HALTED);
      mul_busy  = |mul_cnt_q;
      rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd_q);
      rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd_q);
      // R0 is hardwired, so a load targeting it never blocks a reader.
      load_use  = ex_valid_q & ex_is_load_q & ex_writes_q
                & (|ex_rd_q) & id_valid & (rs1_hit | rs2_hit);
      m_flush   = run & ex_branch_taken;
      m_mul     = run & ~ex_branch_taken & mul_busy;
      m_lu      = run & ~ex_branch_taken & ~mul_busy & load_use;
      issue     = id_valid & run & ~ex_branch_taken
                & ~mul_busy & ~load_use;
   end

   always_comb begin
      stall_r  = 1'b0;
      hold_r   = 1'b0;
      flush_r  = 1'b0;
      bubble_r = 1'b0;
      unique case (1'b1)
         in_halted: begin
            stall_r  = 1'b1;
            hold_r   = 1'b1;
            bubble_r = 1'b1;
         end
         in_drain: begin
            stall_r  = 1'b1;
            flush_r  = 1'b1;
            bubble_r = 1'b1;
         end
         m_flush: begin
            flush_r  = 1'b1;
            bubble_r = 1'b1;
         end
         m_mul: begin
            stall_r  = 1'b1;
            hold_r   = 1'b1;
         end
         m_lu: begin
            stall_r  = 1'b1;
            hold_r   = 1'b1;
            bubble_r = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs are forced quiet while reset is held, whatever ID presents.
   always_comb begin
      stall_pc    = rst & stall_r;
      ifid_hold   = rst & hold_r;
      ifid_flush  = rst & flush_r;
      idex_bubble = rst & bubble_r;
      halted      = rst & in_halted;
      stall_count = stall_cnt_q;
   end

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_rd_d      = ex_rd_q;
      ex_writes_d  = ex_writes_q;
      ex_is_load_d = ex_is_load_q;
      if (issue) begin
         ex_valid_d   = 1'b1;
         ex_rd_d      = id_rd;
         ex_writes_d  = id_writes_rd;
         ex_is_load_d = id_is_load;
      end else if (!mul_busy) begin
         ex_valid_d   = 1'b0;
         ex_rd_d      = 4'd0;
         ex_writes_d  = 1'b0;
         ex_is_load_d = 1'b0;
      end
   end

   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (issue && id_is_mul) begin
         mul_cnt_d = MUL_INIT;
      end else if (mul_busy) begin
         mul_cnt_d = mul_cnt_q - 4'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         S_RUN: begin
            if (issue && id_is_halt) begin
               state_d     = S_DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == '0) begin
               state_d = S_HALTED;
            end else begin
               drain_cnt_d = drain_cnt_q - DW'(1);
            end
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RUN;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_r && (run || in_drain) && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_RUN;
         ex_valid_q   <= 1'b0;
         ex_rd_q      <= 4'd0;
         ex_writes_q  <= 1'b0;
         ex_is_load_q <= 1'b0;
         mul_cnt_q    <= 4'd0;
         drain_cnt_q  <= '0;
         stall_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         ex_valid_q   <= ex_valid_d;
         ex_rd_q      <= ex_rd_d;
         ex_writes_q  <= ex_writes_d;
         ex_is_load_q <= ex_is_load_d;
         mul_cnt_q    <= mul_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, flushes, drain and saturation.
// ctl = {stall_pc, ifid_hold, ifid_flush, idex_bubble, halted}.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_rs1;
   logic [3:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [3:0]  id_rd;
   logic        id_writes_rd;
   logic        id_is_load;
   logic        id_is_mul;
   logic        id_is_halt;
   logic        ex_branch_taken;

   logic        stall_pc, ifid_hold, ifid_flush, idex_bubble, halted;
   logic [15:0] stall_count;
   logic        b_stall_pc, b_ifid_hold, b_ifid_flush;
   logic        b_idex_bubble, b_halted;
   logic [15:0] b_stall_count;

   logic [4:0]  ctl;
   logic [4:0]  b_ctl;
   assign ctl   = {stall_pc, ifid_hold, ifid_flush, idex_bubble, halted};
   assign b_ctl = {b_stall_pc, b_ifid_hold, b_ifid_flush,
                   b_idex_bubble, b_halted};

   int vecs = 0;
   int errs = 0;

   hazard_ctrl #(.MUL_LATENCY(3), .DRAIN_CYCLES(3)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_writes_rd(id_writes_rd),
      .id_is_load(id_is_load), .id_is_mul(id_is_mul),
      .id_is_halt(id_is_halt), .ex_branch_taken(ex_branch_taken),
      .stall_pc(stall_pc), .ifid_hold(ifid_hold),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .halted(halted), .stall_count(stall_count)
   );

   hazard_ctrl #(.MUL_LATENCY(15), .DRAIN_CYCLES(3)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_writes_rd(id_writes_rd),
      .id_is_load(id_is_load), .id_is_mul(id_is_mul),
      .id_is_halt(id_is_halt), .ex_branch_taken(ex_branch_taken),
      .stall_pc(b_stall_pc), .ifid_hold(b_ifid_hold),
      .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble),
      .halted(b_halted), .stall_count(b_stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [3:0] r1,
                         input logic u1, input logic [3:0] r2,
                         input logic u2, input logic [3:0] rd,
                         input logic wr, input logic ld,
                         input logic mul, input logic hlt);
      id_valid     = v;
      id_rs1       = r1;
      id_uses_rs1  = u1;
      id_rs2       = r2;
      id_uses_rs2  = u2;
      id_rd        = rd;
      id_writes_rd = wr;
      id_is_load   = ld;
      id_is_mul    = mul;
      id_is_halt   = hlt;
   endtask

   task automatic clr_id();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ex_branch_taken = 1'b1;
      set_id(1, 3, 1, 3, 1, 3, 1, 1, 1, 1);
      #2;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL rst_low_ctl: got %b exp %b", ctl, 5'b00000);
      end
      vecs++;
      if (stall_count !== 16'd0) begin
         errs++;
         $display("FAIL rst_low_cnt: got %0d exp 0", stall_count);
      end
      tick();
      tick();
      rst = 1'b1;
      ex_branch_taken = 1'b0;
      clr_id();
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL rst_rel_ctl: got %b exp %b", ctl, 5'b00000);
      end
   endtask

   task automatic test_load_use();
      set_id(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL lu_load_issue: got %b exp %b", ctl, 5'b00000);
      end
      tick();
      set_id(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b11010) begin
         errs++;
         $display("FAIL lu_stall: got %b exp %b", ctl, 5'b11010);
      end
      tick();
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL lu_release: got %b exp %b", ctl, 5'b00000);
      end
      vecs++;
      if (stall_count !== 16'd1) begin
         errs++;
         $display("FAIL lu_count: got %0d exp 1", stall_count);
      end
      tick();
   endtask

   task automatic test_no_hazard();
      set_id(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tick();
      set_id(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL r0_use: got %b exp %b", ctl, 5'b00000);
      end
      tick();
      set_id(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      set_id(1, 3, 0, 2, 1, 6, 0, 0, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL rs1_unused: got %b exp %b", ctl, 5'b00000);
      end
      tick();
      set_id(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      set_id(1, 1, 0, 3, 1, 7, 0, 0, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b11010) begin
         errs++;
         $display("FAIL rs2_stall: got %b exp %b", ctl, 5'b11010);
      end
      tick();
      vecs++;
      if (stall_count !== 16'd2) begin
         errs++;
         $display("FAIL rs2_count: got %0d exp 2", stall_count);
      end
      tick();
   endtask

   task automatic test_mul();
      set_id(1, 1, 1, 2, 1, 5, 1, 0, 1, 0);
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL mul_issue: got %b exp %b", ctl, 5'b00000);
      end
      tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1;
         vecs++;
         if (ctl !== 5'b11000) begin
            errs++;
            $display("FAIL mul_busy%0d: got %b exp %b", i, ctl, 5'b11000);
         end
         tick();
      end
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL mul_dep_issue: got %b exp %b", ctl, 5'b00000);
      end
      vecs++;
      if (stall_count !== 16'd4) begin
         errs++;
         $display("FAIL mul_count: got %0d exp 4", stall_count);
      end
      tick();
      clr_id();
   endtask

   task automatic test_branch();
      set_id(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      set_id(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
      ex_branch_taken = 1'b1;
      #1;
      vecs++;
      if (ctl !== 5'b00110) begin
         errs++;
         $display("FAIL br_flush: got %b exp %b", ctl, 5'b00110);
      end
      tick();
      ex_branch_taken = 1'b0;
      clr_id();
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL br_halt_killed: got %b exp %b", ctl, 5'b00000);
      end
      tick();
   endtask

   task automatic test_halt();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL halt_issue: got %b exp %b", ctl, 5'b00000);
      end
      tick();
      clr_id();
      for (int i = 1; i <= 3; i++) begin
         #1;
         vecs++;
         if (ctl !== 5'b10110) begin
            errs++;
            $display("FAIL drain_n%0d: got %b exp %b", i, ctl, 5'b10110);
         end
         tick();
      end
      vecs++;
      if (ctl !== 5'b11011) begin
         errs++;
         $display("FAIL halted_n4: got %b exp %b", ctl, 5'b11011);
      end
      ex_branch_taken = 1'b1;
      #1;
      vecs++;
      if (ctl !== 5'b11011) begin
         errs++;
         $display("FAIL halted_br: got %b exp %b", ctl, 5'b11011);
      end
      tick();
      tick();
      ex_branch_taken = 1'b0;
      vecs++;
      if (ctl !== 5'b11011) begin
         errs++;
         $display("FAIL halted_hold: got %b exp %b", ctl, 5'b11011);
      end
      vecs++;
      if (stall_count !== 16'd7) begin
         errs++;
         $display("FAIL halt_count: got %0d exp 7", stall_count);
      end
   endtask

   task automatic test_reset_mid_drain();
      rst = 1'b0;
      #2;
      vecs++;
      if ({ctl, stall_count} !== 21'd0) begin
         errs++;
         $display("FAIL rst_halted: got %b/%0d exp 0", ctl, stall_count);
      end
      rst = 1'b1;
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      tick();
      clr_id();
      tick();
      vecs++;
      if (ctl !== 5'b10110) begin
         errs++;
         $display("FAIL drain2: got %b exp %b", ctl, 5'b10110);
      end
      vecs++;
      if (stall_count !== 16'd1) begin
         errs++;
         $display("FAIL drain2_cnt: got %0d exp 1", stall_count);
      end
      rst = 1'b0;
      #1;
      vecs++;
      if ({ctl, stall_count} !== 21'd0) begin
         errs++;
         $display("FAIL rst_drain: got %b/%0d exp 0", ctl, stall_count);
      end
      rst = 1'b1;
      set_id(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b00000) begin
         errs++;
         $display("FAIL rst_run: got %b exp %b", ctl, 5'b00000);
      end
      tick();
      set_id(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
      #1;
      vecs++;
      if (ctl !== 5'b11010) begin
         errs++;
         $display("FAIL rst_run_lu: got %b exp %b", ctl, 5'b11010);
      end
      tick();
      clr_id();
   endtask

   task automatic test_saturate();
      logic [4:0] exp_ctl;
      rst = 1'b0;
      set_id(1, 3, 1, 0, 0, 3, 1, 1, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      vecs++;
      if (b_ctl !== 5'b00000) begin
         errs++;
         $display("FAIL sat_c0: got %b exp %b", b_ctl, 5'b00000);
      end
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 16) exp_ctl = 5'b00000;
         else if (c == 15) exp_ctl = 5'b11010;
         else exp_ctl = 5'b11000;
         vecs++;
         if (b_ctl !== exp_ctl) begin
            errs++;
            $display("FAIL sat_c%0d: got %b exp %b", c, b_ctl, exp_ctl);
         end
      end
      vecs++;
      if (b_stall_count !== 16'd15) begin
         errs++;
         $display("FAIL sat_cnt16: got %0d exp 15", b_stall_count);
      end
      for (int c = 17; c <= 70000; c++) begin
         tick();
         if (c == 1600) begin
            vecs++;
            if (b_stall_count !== 16'd1500) begin
               errs++;
               $display("FAIL sat_cnt1600: got %0d exp 1500", b_stall_count);
            end
         end
      end
      vecs++;
      if (b_stall_count !== 16'hFFFF) begin
         errs++;
         $display("FAIL sat_full: got %h exp ffff", b_stall_count);
      end
      repeat (100) tick();
      vecs++;
      if (b_stall_count !== 16'hFFFF) begin
         errs++;
         $display("FAIL sat_hold: got %h exp ffff", b_stall_count);
      end
      clr_id();
   endtask

   initial begin
      rst = 1'b0;
      ex_branch_taken = 1'b0;
      clr_id();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_mul();
      test_branch();
      test_halt();
      test_reset_mid_drain();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
